// File: rtl/ign_multi_driver_if.sv
// Coil driver bundle: angle/timing inputs from the crank decoder,
// coil drive and fault flags back out.
interface ign_multi_driver_if #(
   parameter int N_CYL   = 4,
   parameter int ANGLE_W = 16,
   parameter int QP_W    = 16,
   parameter int DWELL_W = 24
);

   logic                       en;
   logic                       trigger;
   logic [ANGLE_W-1:0]         eng_phase;
   logic [ANGLE_W-1:0]         next_tooth_width;
   logic [QP_W-1:0]            quantum_period;
   logic [ANGLE_W-1:0]         quanta_per_revolution;
   logic [ANGLE_W-1:0]         ign_timing;
   logic [ANGLE_W-1:0]         dwell_angle;
   logic [N_CYL*ANGLE_W-1:0]   cyl_phase;
   logic [DWELL_W-1:0]         max_dwell_ticks;
   logic                       fault_clr;
   logic [N_CYL-1:0]           spk_out;
   logic [N_CYL-1:0]           fault;

   modport master (
      output en,
      output trigger,
      output eng_phase,
      output next_tooth_width,
      output quantum_period,
      output quanta_per_revolution,
      output ign_timing,
      output dwell_angle,
      output cyl_phase,
      output max_dwell_ticks,
      output fault_clr,
      input  spk_out,
      input  fault
   );

   modport slave (
      input  en,
      input  trigger,
      input  eng_phase,
      input  next_tooth_width,
      input  quantum_period,
      input  quanta_per_revolution,
      input  ign_timing,
      input  dwell_angle,
      input  cyl_phase,
      input  max_dwell_ticks,
      input  fault_clr,
      output spk_out,
      output fault
   );

endinterface

// File: rtl/ign_multi_driver.sv
// Multi-channel ignition coil driver: per-channel charge/fire countdowns
// armed from tooth edges, with over-dwell protection and sticky faults.
module ign_multi_driver #(
   parameter int N_CYL   = 4,
   parameter int ANGLE_W = 16,
   parameter int QP_W    = 16,
   parameter int DWELL_W = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   ign_multi_driver_if.slave     bus
);

   localparam int AW2 = ANGLE_W + 2;
   localparam int TW  = ANGLE_W + QP_W;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] ARMED = 1'b1;

   function automatic logic [AW2-1:0] mod_add(
      input logic [AW2-1:0] a,
      input logic [AW2-1:0] b,
      input logic [AW2-1:0] q
   );
      logic [AW2-1:0] s;
      s = a + b;
      if (s >= q) s = s - q;
      if (s >= q) s = s - q;
      return s;
   endfunction

   // Negative differences show up as the top bit of the widened result.
   function automatic logic [AW2-1:0] mod_sub(
      input logic [AW2-1:0] a,
      input logic [AW2-1:0] b,
      input logic [AW2-1:0] q
   );
      logic [AW2-1:0] d;
      d = a - b;
      if (d[AW2-1]) d = d + q;
      if (d[AW2-1]) d = d + q;
      return d;
   endfunction

   function automatic logic [TW:0] tmr_next(
      input logic          st,
      input logic [TW-1:0] cnt,
      input logic          go,
      input logic [TW-1:0] dly,
      input logic          en
   );
      logic [TW:0] r;
      r = {st, cnt};
      if (!en) begin
         r = {IDLE, {TW{1'b0}}};
      end else if (st == ARMED) begin
         if (cnt == '0) r = {IDLE, cnt};
         else           r = {ARMED, cnt - 1'b1};
      end else if (go) begin
         r = {ARMED, dly};
      end
      return r;
   endfunction

   logic [AW2-1:0]     q_x;
   logic [AW2-1:0]     ph_x;
   logic [AW2-1:0]     ntw_x;
   logic [AW2-1:0]     fire_a   [N_CYL];
   logic [AW2-1:0]     chg_a    [N_CYL];
   logic [AW2-1:0]     fire_off [N_CYL];
   logic [AW2-1:0]     chg_off  [N_CYL];
   logic [TW-1:0]      fire_dly [N_CYL];
   logic [TW-1:0]      chg_dly  [N_CYL];
   logic [N_CYL-1:0]   fire_win;
   logic [N_CYL-1:0]   chg_win;

   logic [N_CYL-1:0]   chg_st_q,  chg_st_d;
   logic [N_CYL-1:0]   fire_st_q, fire_st_d;
   logic [TW-1:0]      chg_cnt_q  [N_CYL];
   logic [TW-1:0]      chg_cnt_d  [N_CYL];
   logic [TW-1:0]      fire_cnt_q [N_CYL];
   logic [TW-1:0]      fire_cnt_d [N_CYL];
   logic [N_CYL-1:0]   chg_exp;
   logic [N_CYL-1:0]   fire_exp;

   logic [N_CYL-1:0]   spk_q,   spk_d;
   logic [N_CYL-1:0]   fault_q, fault_d;
   logic [DWELL_W-1:0] dwl_q   [N_CYL];
   logic [DWELL_W-1:0] dwl_d   [N_CYL];
   logic [DWELL_W-1:0] dwl_inc;
   logic [N_CYL-1:0]   over;

   assign q_x   = AW2'(bus.quanta_per_revolution);
   assign ph_x  = AW2'(bus.eng_phase);
   assign ntw_x = AW2'(bus.next_tooth_width);

   always_comb begin
      for (int i = 0; i < N_CYL; i++) begin
         fire_a[i] = mod_add(AW2'(bus.ign_timing),
                             AW2'(bus.cyl_phase[i*ANGLE_W +: ANGLE_W]),
                             q_x);
         chg_a[i]  = mod_sub(fire_a[i], AW2'(bus.dwell_angle), q_x);

         fire_off[i] = mod_sub(fire_a[i], ph_x, q_x);
         chg_off[i]  = mod_sub(chg_a[i],  ph_x, q_x);

         fire_win[i] = fire_off[i] < ntw_x;
         chg_win[i]  = chg_off[i]  < ntw_x;

         fire_dly[i] = TW'(fire_off[i]) * TW'(bus.quantum_period);
         chg_dly[i]  = TW'(chg_off[i])  * TW'(bus.quantum_period);
      end
   end

   // A timer that is already counting ignores further tooth edges.
   always_comb begin
      for (int i = 0; i < N_CYL; i++) begin
         chg_exp[i]  = bus.en && chg_st_q[i] == ARMED &&
                       chg_cnt_q[i] == '0;
         fire_exp[i] = bus.en && fire_st_q[i] == ARMED &&
                       fire_cnt_q[i] == '0;

         {chg_st_d[i], chg_cnt_d[i]} =
            tmr_next(chg_st_q[i], chg_cnt_q[i],
                     bus.trigger && chg_win[i], chg_dly[i], bus.en);
         {fire_st_d[i], fire_cnt_d[i]} =
            tmr_next(fire_st_q[i], fire_cnt_q[i],
                     bus.trigger && fire_win[i], fire_dly[i], bus.en);
      end
   end

   // Fire and over-dwell both beat a coincident charge expiry.
   always_comb begin
      spk_d   = spk_q;
      over    = '0;
      dwl_inc = '0;
      for (int i = 0; i < N_CYL; i++) begin
         dwl_inc = (&dwl_q[i]) ? dwl_q[i] : dwl_q[i] + 1'b1;
         over[i] = bus.en && spk_q[i] &&
                   bus.max_dwell_ticks != '0 &&
                   dwl_inc >= bus.max_dwell_ticks;

         if (!bus.en || fire_exp[i] || over[i])
            spk_d[i] = 1'b0;
         else if (chg_exp[i])
            spk_d[i] = 1'b1;

         dwl_d[i] = (spk_q[i] && spk_d[i]) ? dwl_inc : '0;
      end
      fault_d = (bus.fault_clr ? '0 : fault_q) | over;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chg_st_q  <= {N_CYL{IDLE}};
         fire_st_q <= {N_CYL{IDLE}};
         spk_q     <= '0;
         fault_q   <= '0;
         for (int i = 0; i < N_CYL; i++) begin
            chg_cnt_q[i]  <= '0;
            fire_cnt_q[i] <= '0;
            dwl_q[i]      <= '0;
         end
      end else begin
         chg_st_q  <= chg_st_d;
         fire_st_q <= fire_st_d;
         spk_q     <= spk_d;
         fault_q   <= fault_d;
         for (int i = 0; i < N_CYL; i++) begin
            chg_cnt_q[i]  <= chg_cnt_d[i];
            fire_cnt_q[i] <= fire_cnt_d[i];
            dwl_q[i]      <= dwl_d[i];
         end
      end
   end

   assign bus.spk_out = spk_q;
   assign bus.fault   = fault_q;

endmodule

// File: doc/ign_multi_driver.md
IGN_MULTI_DRIVER -- requirements
Module: ign_multi_driver

Interface
REQ-001 SHALL have parameter N_CYL, default 4, number of coil channels (1..16).
REQ-002 SHALL have parameter ANGLE_W, default 16, angle width in quanta.
REQ-003 SHALL have parameter QP_W, default 16, width of clocks-per-quantum.
REQ-004 SHALL have parameter DWELL_W, default 24, width of the max-dwell limit and counter.
REQ-005 SHALL have the following ports; one clock, reset asynchronous and active-high:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- en  in  1  global enable; 0 forces all coils off.
- trigger  in  1  one-cycle tooth-edge strobe.
- eng_phase  in  ANGLE_W  engine angle at the current tooth.
- next_tooth_width  in  ANGLE_W  quanta until the next tooth.
- quantum_period  in  QP_W  clocks per angle quantum.
- quanta_per_revolution  in  ANGLE_W  cycle length Q.
- ign_timing  in  ANGLE_W  base fire angle.
- dwell_angle  in  ANGLE_W  charge lead angle, less than Q.
- cyl_phase  in  N_CYL*ANGLE_W  per-channel phase offsets; channel i occupies bits [i*ANGLE_W +: ANGLE_W].
- max_dwell_ticks  in  DWELL_W  dwell limit in clocks; 0 disables the limit.
- fault_clr  in  1  clears all fault bits.
- spk_out  out  N_CYL  coil drive; 1 = charging.
- fault  out  N_CYL  sticky over-dwell flags.

Function
REQ-006 SHALL compute per channel fire_i = (ign_timing + cyl_phase_i) mod Q, using ANGLE_W+2-bit intermediates with no overflow.
REQ-007 SHALL compute charge_i = (fire_i - dwell_angle) mod Q, adding Q when the difference is negative.
REQ-008 SHALL treat an event angle A as "in window" on a trigger when off = (A - eng_phase) mod Q satisfies off < next_tooth_width.
REQ-009 SHALL give each channel two independent countdown timers, CHG and FIRE, each with states IDLE and ARMED.
REQ-010 SHALL arm an IDLE timer, on a trigger with en=1 and its angle in window, with D = off * quantum_period (ANGLE_W+QP_W bits, unsaturated).
REQ-011 SHALL ignore a trigger for an ARMED timer; the pending countdown is not reloaded.
REQ-012 SHALL, for a timer armed at edge T0, change spk_out at edge T0+D+1; D=0 changes it at T0+1. The timer then returns to IDLE.
REQ-013 SHALL set spk_out[i] on a CHG expiry and clear it on a FIRE expiry; simultaneous expiry clears it (fire wins).
REQ-014 SHALL count clocks while spk_out[i]=1 and reset the count to 0 whenever spk_out[i]=0.
REQ-015 SHALL, when max_dwell_ticks≠0 and the count reaches max_dwell_ticks, clear spk_out[i] at that edge and set fault[i].
REQ-016 SHALL, after a forced clear, not set spk_out[i] again until the next CHG expiry.
REQ-017 SHALL, while en=0, hold spk_out at 0, force all timers to IDLE and ignore trigger; fault is retained.
REQ-018 SHALL clear all fault bits one edge after fault_clr=1; an over-dwell in the same cycle wins (bit stays set).
REQ-019 SHALL require input changes other than trigger, en and fault_clr only to take effect at the next arming.

Reset
REQ-020 SHALL, on rst=1, immediately clear spk_out, fault, all timers (IDLE) and all dwell counters, independent of clk.
REQ-021 SHALL, after rst deasserts, ignore triggers before the first rising clk edge; no event is pending.
REQ-022 SHALL, on rst mid-charge, drop spk_out to 0 asynchronously and not resume it.

Verification
Common setup: N_CYL=4, Q=720, cyl_phase={0,180,360,540}, ign_timing=100, dwell_angle=50, quantum_period=10, next_tooth_width=12, max_dwell_ticks=0.
REQ-023 Basic: trigger at eng_phase=48 -> spk_out[0] rises 21 edges after the trigger edge; trigger at eng_phase=96 -> spk_out[0] falls 41 edges after that trigger edge.
REQ-024 Wrap: cyl_phase_3=660 -> fire_3=40, charge_3=710; trigger at eng_phase=708 -> spk_out[3] rises after 21 edges.
REQ-025 Over-dwell: max_dwell_ticks=100, charge fires with no fire trigger -> spk_out[0] clears 100 edges after rising and fault[0]=1; fault_clr pulse -> fault[0]=0.
REQ-026 Enable drop: en=0 mid-charge with FIRE armed -> spk_out=0 next edge and no later transition; en=1 again with no trigger -> output stays 0.
REQ-027 Collision: dwell_angle=0 -> charge and fire expire together -> spk_out[0] stays 0; rst pulse mid-countdown -> no event occurs afterwards.
